// File: rtl/ntt_pass_sequencer.sv
// ntt_pass_sequencer
//
// Purpose:
//   Breaks one LOG_N-level NTT or inverse NTT into passes of at most LOG_E
//   butterfly levels. It starts those passes one at a time on the shared
//   forward or inverse NTT control engine. Two requesters compete for the
//   engines (0: keyswitch path, 1: host/DMA), and a round-robin pointer picks
//   between them when both ask at once. Only one transform is in flight.
//
// Ports:
//   clk                  clock
//   rstn                 synchronous, active-low reset
//   req_i[1:0]           per-requester transform request, held until ack
//   req_inv_i[1:0]       per-requester direction: 1 = inverse, 0 = forward
//   req_p_i[2*FSIZE-1:0] per-requester modulus, requester i at [FSIZE*i +: FSIZE]
//   ack_o[1:0]           one-cycle pulse: request i accepted, operands latched
//   done_o[1:0]          one-cycle pulse: last pass of requester i finished
//   busy_o               transform in progress, from the ack cycle to the done cycle
//   fwd_start_o          one-cycle start pulse to the forward engine
//   inv_start_o          one-cycle start pulse to the inverse engine
//   eng_p_o              latched modulus for the engines
//   eng_levels_o         butterfly levels in the current pass (1..LOG_E)
//   eng_base_level_o     lowest butterfly level of the current pass
//   fwd_working_i        forward engine busy (rises the cycle after its start)
//   inv_working_i        inverse engine busy
module ntt_pass_sequencer #(
    parameter int LOG_N = 12,
    parameter int LOG_E = 3,
    parameter int FSIZE = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 req_inv_i,
    input  logic [2*FSIZE-1:0]         req_p_i,
    output logic [1:0]                 ack_o,
    output logic [1:0]                 done_o,
    output logic                       busy_o,
    output logic                       fwd_start_o,
    output logic                       inv_start_o,
    output logic [FSIZE-1:0]           eng_p_o,
    output logic [$clog2(LOG_E+1)-1:0] eng_levels_o,
    output logic [$clog2(LOG_N)-1:0]   eng_base_level_o,
    input  logic                       fwd_working_i,
    input  logic                       inv_working_i
);

    localparam int NPASS = (LOG_N + LOG_E - 1) / LOG_E;
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int LW    = $clog2(LOG_E + 1);
    localparam int BW    = $clog2(LOG_N);
    localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             grant_q, grant_d;
    logic             inv_q, inv_d;
    logic [FSIZE-1:0] p_q, p_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic [LW-1:0]    levels_q, levels_d;
    logic [BW-1:0]    base_q, base_d;

    logic             grant_sel;
    logic             working;
    logic             last_pass;
    logic [PW-1:0]    first_pass;
    logic [PW-1:0]    next_pass;

    function automatic logic [BW-1:0] baseOf(input logic [PW-1:0] k);
        return BW'(int'(k) * LOG_E);
    endfunction

    // The top pass may hold fewer than LOG_E levels when LOG_E does not divide LOG_N.
    function automatic logic [LW-1:0] levelsOf(input logic [PW-1:0] k);
        int remaining;
        remaining = LOG_N - int'(k) * LOG_E;
        if (remaining > LOG_E) begin
            remaining = LOG_E;
        end
        return LW'(remaining);
    endfunction

    // A lone requester wins outright; the pointer only breaks ties.
    assign grant_sel = (req_i == 2'b11) ? rr_q : req_i[1];

    // Only the engine matching the latched direction is watched.
    assign working   = inv_q ? inv_working_i : fwd_working_i;

    // Inverse transforms walk the passes from the top level down.
    assign last_pass  = inv_q ? (pass_q == '0) : (pass_q == LAST_PASS);
    assign next_pass  = inv_q ? (pass_q - PW'(1)) : (pass_q + PW'(1));
    assign first_pass = req_inv_i[grant_sel] ? LAST_PASS : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            grant_q  <= 1'b0;
            inv_q    <= 1'b0;
            p_q      <= '0;
            pass_q   <= '0;
            levels_q <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            inv_q    <= inv_d;
            p_q      <= p_d;
            pass_q   <= pass_d;
            levels_q <= levels_d;
            base_q   <= base_d;
        end
    end

    // The pulse outputs are decoded from the state, so they are gated by rstn.
    // That keeps every output quiet while reset is held.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        inv_d       = inv_q;
        p_d         = p_q;
        pass_d      = pass_q;
        levels_d    = levels_q;
        base_d      = base_q;
        ack_o       = 2'b00;
        done_o      = 2'b00;
        fwd_start_o = 1'b0;
        inv_start_o = 1'b0;
        busy_o      = 1'b0;

        if (rstn) begin
            busy_o = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        ack_o    = grant_sel ? 2'b10 : 2'b01;
                        busy_o   = 1'b1;
                        grant_d  = grant_sel;
                        rr_d     = ~grant_sel;
                        inv_d    = req_inv_i[grant_sel];
                        p_d      = grant_sel ? req_p_i[2*FSIZE-1:FSIZE] : req_p_i[FSIZE-1:0];
                        pass_d   = first_pass;
                        levels_d = levelsOf(first_pass);
                        base_d   = baseOf(first_pass);
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    fwd_start_o = ~inv_q;
                    inv_start_o = inv_q;
                    state_d     = WAIT_HI;
                end
                WAIT_HI: begin
                    if (working) begin
                        state_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!working) begin
                        if (last_pass) begin
                            state_d = DONE;
                        end else begin
                            pass_d   = next_pass;
                            levels_d = levelsOf(next_pass);
                            base_d   = baseOf(next_pass);
                            state_d  = ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_o  = grant_q ? 2'b10 : 2'b01;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign eng_p_o          = p_q;
    assign eng_levels_o     = levels_q;
    assign eng_base_level_o = base_q;

endmodule
